// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the unified-memory port arbiter.
// Covers FSM states, grant encoding and counter sizing.
package mips_mem_pkg;

  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_STARVE_LIM = 4;
  localparam int DEF_TIMEOUT    = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2,
    DONE    = 2'd3
  } state_t;

  typedef enum logic {
    GRANT_IF = 1'b0,
    GRANT_DM = 1'b1
  } grant_t;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Single-port memory req/ack bus; the arbiter is master, the memory is slave.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/mem_port_arbiter_timeout_ctr.sv
// Busy-cycle timer: cleared at grant, counts while enabled, flags the last allowed cycle.
module mem_timeout_ctr
  import mips_mem_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic hit
);

  localparam int              CNT_W   = cnt_width(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HIT_VAL = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && !hit) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign hit = (count_reg == HIT_VAL);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data access,
// with DM priority, an IF starvation guard and a busy timeout.
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_LIM = DEF_STARVE_LIM,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              dm_stall,
  mem_port_arbiter_if.master bus,
  output logic              err
);

  localparam int              ST_W   = cnt_width(STARVE_LIM);
  localparam logic [ST_W-1:0] ST_LIM = ST_W'(STARVE_LIM);

  state_t            state_reg, state_next;
  grant_t            owner_reg, grant_sel;
  logic              grant_valid;
  logic [ST_W-1:0]   starve_reg;
  logic              mem_req_reg, mem_we_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [DATA_W-1:0] mem_wdata_reg;
  logic [DATA_W-1:0] if_rdata_reg, dm_rdata_reg, capture_data;
  logic              drop_reg, err_reg;
  logic              busy, finish;
  logic              timer_clear, timer_enable, timer_hit;

  mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .enable (timer_enable),
    .hit    (timer_hit)
  );

  // IF wins only once it has lost STARVE_LIM arbitrations in a row.
  always_comb begin
    grant_valid = if_req | dm_req;
    grant_sel   = (dm_req && !(if_req && starve_reg == ST_LIM)) ? GRANT_DM : GRANT_IF;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (grant_valid) begin
          state_next = (grant_sel == GRANT_DM) ? BUSY_DM : BUSY_IF;
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (finish) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state_reg == BUSY_IF) || (state_reg == BUSY_DM);
    finish       = busy && (bus.mem_ack || timer_hit);
    timer_clear  = (state_reg == IDLE) && grant_valid;
    timer_enable = busy;
    // A flush arriving in the DONE cycle itself still hides the fetch result.
    if_valid     = (state_reg == DONE) && (owner_reg == GRANT_IF) && !drop_reg && !if_flush;
    dm_valid     = (state_reg == DONE) && (owner_reg == GRANT_DM);
    if_stall     = if_req && !if_valid;
    dm_stall     = dm_req && !dm_valid;
    // Stores and aborted accesses return zero.
    capture_data = (bus.mem_ack && !mem_we_reg) ? bus.mem_rdata : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_reg     <= GRANT_IF;
      starve_reg    <= '0;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      if_rdata_reg  <= '0;
      dm_rdata_reg  <= '0;
      drop_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_valid) begin
            mem_req_reg <= 1'b1;
            owner_reg   <= grant_sel;
            if (grant_sel == GRANT_DM) begin
              mem_we_reg    <= dm_we;
              mem_addr_reg  <= dm_addr;
              mem_wdata_reg <= dm_wdata;
              if (if_req && starve_reg != ST_LIM) begin
                starve_reg <= starve_reg + ST_W'(1);
              end
            end else begin
              mem_we_reg    <= 1'b0;
              mem_addr_reg  <= if_addr;
              mem_wdata_reg <= '0;
              starve_reg    <= '0;
            end
          end
        end
        BUSY_IF, BUSY_DM: begin
          if (state_reg == BUSY_IF && if_flush) begin
            drop_reg <= 1'b1;
          end
          if (finish) begin
            mem_req_reg <= 1'b0;
            if (!bus.mem_ack) begin
              err_reg <= 1'b1;
            end
            if (owner_reg == GRANT_DM) begin
              dm_rdata_reg <= capture_data;
            end else begin
              if_rdata_reg <= capture_data;
            end
          end
        end
        DONE:    drop_reg <= 1'b0;
        default: drop_reg <= 1'b0;
      endcase
    end
  end

  assign bus.mem_req   = mem_req_reg;
  assign bus.mem_we    = mem_we_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wdata = mem_wdata_reg;
  assign if_rdata      = if_rdata_reg;
  assign dm_rdata      = dm_rdata_reg;
  assign err           = err_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized + directed bench for mem_port_arbiter against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SLIM = 4;
  localparam int TMO  = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_req = 1'b0, if_flush = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          dm_req = 1'b0, dm_we = 1'b0;
  logic [AW-1:0] dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] if_rdata, dm_rdata;
  logic          if_valid, if_stall, dm_valid, dm_stall, err;

  int errors = 0;
  int checks = 0;
  bit auto_mem = 1'b0;
  bit auto_req = 1'b0;
  int ack_pct  = 100;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  assign bus.mem_ack   = mem_ack;
  assign bus.mem_rdata = mem_rdata;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIM(SLIM), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_stall(dm_stall),
    .bus(bus), .err(err)
  );

  always #5 clk = ~clk;

  // Reference model: 0 = memory free, 1 = access in flight, 2 = result cycle.
  int          m_phase, m_age, m_starve;
  bit          m_dm, m_we, m_drop, m_err;
  logic [31:0] m_addr, m_wdata, m_res;

  function automatic bit pick_dm();
    return dm_req && !(if_req && m_starve == SLIM);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase <= 0; m_age <= 0; m_starve <= 0;
      m_dm <= 1'b0; m_we <= 1'b0; m_drop <= 1'b0; m_err <= 1'b0;
      m_addr <= '0; m_wdata <= '0; m_res <= '0;
    end else begin
      case (m_phase)
        0: if (if_req || dm_req) begin
          m_dm     <= pick_dm();
          m_we     <= pick_dm() ? dm_we : 1'b0;
          m_addr   <= pick_dm() ? dm_addr : if_addr;
          m_wdata  <= pick_dm() ? dm_wdata : 32'd0;
          m_starve <= !pick_dm() ? 0 : (if_req && m_starve < SLIM) ? m_starve + 1 : m_starve;
          m_drop   <= 1'b0;
          m_age    <= 0;
          m_phase  <= 1;
        end
        1: begin
          if (!m_dm && if_flush) m_drop <= 1'b1;
          m_age <= m_age + 1;
          if (mem_ack) begin
            m_res   <= m_we ? 32'd0 : mem_rdata;
            m_phase <= 2;
          end else if (m_age + 1 == TMO) begin
            m_res   <= 32'd0;
            m_err   <= 1'b1;
            m_phase <= 2;
          end
        end
        default: m_phase <= 0;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    logic e_mreq, e_ifv, e_dmv;
    e_mreq = (m_phase == 1);
    e_ifv  = (m_phase == 2) && !m_dm && !m_drop && !if_flush;
    e_dmv  = (m_phase == 2) && m_dm;
    chk_b("mem_req", bus.mem_req, e_mreq);
    chk_b("if_valid", if_valid, e_ifv);
    chk_b("dm_valid", dm_valid, e_dmv);
    chk_b("if_stall", if_stall, if_req && !e_ifv);
    chk_b("dm_stall", dm_stall, dm_req && !e_dmv);
    chk_b("err", err, m_err);
    if (e_mreq) begin
      chk_b("mem_we", bus.mem_we, m_we);
      chk("mem_addr", bus.mem_addr, m_addr);
      chk("mem_wdata", bus.mem_wdata, m_wdata);
    end
    if (e_ifv) begin
      chk("if_rdata", if_rdata, m_res);
      $display("txn IF addr=%h rdata=%h", m_addr, m_res);
    end
    if (e_dmv) begin
      chk("dm_rdata", dm_rdata, m_res);
      $display("txn DM we=%0d addr=%h wdata=%h rdata=%h", m_we, m_addr, m_wdata, m_res);
    end
  endtask

  task automatic auto_drive();
    if (auto_mem) begin
      mem_rdata = $urandom;
      if (m_phase == 1) mem_ack = ($urandom_range(99) < ack_pct);
      else              mem_ack = ($urandom_range(4) == 0);
    end
    if (auto_req) begin
      if_flush = 1'b0;
      if (!m_dm && m_phase == 2) begin
        if_req   = ($urandom_range(1) == 1);
        if_addr  = $urandom;
        if_flush = ($urandom_range(7) == 0);
      end else if (!m_dm && m_phase == 1) begin
        if_flush = ($urandom_range(7) == 0);
        if ($urandom_range(39) == 0) if_req = 1'b0;
      end else if (!if_req && $urandom_range(2) == 0) begin
        if_req  = 1'b1;
        if_addr = $urandom;
      end
      if (m_dm && m_phase == 2) begin
        dm_req   = ($urandom_range(1) == 1);
        dm_we    = ($urandom_range(1) == 1);
        dm_addr  = $urandom;
        dm_wdata = $urandom;
      end else if (m_dm && m_phase == 1) begin
        if ($urandom_range(39) == 0) dm_req = 1'b0;
      end else if (!dm_req && $urandom_range(2) == 0) begin
        dm_req   = 1'b1;
        dm_we    = ($urandom_range(1) == 1);
        dm_addr  = $urandom;
        dm_wdata = $urandom;
      end
    end
  endtask

  // Closes the current cycle: check it, then move to the next falling edge.
  task automatic tick();
    #1;
    if (rst) compare_model();
    @(negedge clk);
    auto_drive();
  endtask

  task automatic drain();
    auto_req = 1'b0;
    if_req = 1'b0; dm_req = 1'b0; if_flush = 1'b0;
    for (int i = 0; i < 200 && m_phase != 0; i++) tick();
    tick();
    #1 chk_b("drain_idle", bus.mem_req, 1'b0);
  endtask

  task automatic run_random(input int n, input int pct);
    auto_mem = 1'b1; auto_req = 1'b1; ack_pct = pct;
    for (int i = 0; i < n; i++) tick();
    drain();
    auto_mem = 1'b0; mem_ack = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dm_grants, hi_cnt, pulses;
    bit if_seen, prev;

    repeat (2) @(negedge clk);
    #1;
    chk_b("rst_mem_req", bus.mem_req, 1'b0);
    chk_b("rst_if_valid", if_valid, 1'b0);
    chk_b("rst_dm_valid", dm_valid, 1'b0);
    chk_b("rst_err", err, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // Single fetch, ack in the first busy cycle.
    if_req = 1'b1; if_addr = 32'h10;
    tick();
    #1;
    chk_b("t1_mem_req", bus.mem_req, 1'b1);
    chk("t1_mem_addr", bus.mem_addr, 32'h10);
    chk_b("t1_mem_we", bus.mem_we, 1'b0);
    mem_ack = 1'b1; mem_rdata = 32'h2002_0005;
    tick();
    mem_ack = 1'b0; if_req = 1'b0;
    #1;
    chk_b("t1_if_valid", if_valid, 1'b1);
    chk("t1_if_rdata", if_rdata, 32'h2002_0005);
    chk_b("t1_if_stall", if_stall, 1'b0);
    tick();
    #1 chk_b("t1_if_valid_off", if_valid, 1'b0);
    tick();

    // Simultaneous requests: store wins, then fetch.
    if_req = 1'b1; if_addr = 32'h20;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'hDEAD_BEEF;
    tick();
    #1;
    chk_b("t2_mem_we", bus.mem_we, 1'b1);
    chk("t2_mem_addr", bus.mem_addr, 32'h40);
    chk("t2_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    tick();
    mem_ack = 1'b0; dm_req = 1'b0;
    #1;
    chk_b("t2_dm_valid", dm_valid, 1'b1);
    chk("t2_dm_rdata", dm_rdata, 32'h0);
    tick();
    tick();
    #1;
    chk("t2_if_addr", bus.mem_addr, 32'h20);
    chk_b("t2_if_we", bus.mem_we, 1'b0);
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
    tick();
    mem_ack = 1'b0; if_req = 1'b0;
    #1;
    chk_b("t2_if_valid", if_valid, 1'b1);
    chk("t2_if_rdata", if_rdata, 32'h0BAD_F00D);
    tick();

    // Starvation guard: back-to-back loads while fetch waits.
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h80;
    if_req = 1'b1; if_addr = 32'h30;
    auto_mem = 1'b1; ack_pct = 100;
    dm_grants = 0; if_seen = 1'b0; prev = 1'b0;
    for (int i = 0; i < 60 && !if_seen; i++) begin
      tick();
      #1;
      if (bus.mem_req && !prev) begin
        if (bus.mem_addr == 32'h30) if_seen = 1'b1;
        else dm_grants++;
      end
      prev = bus.mem_req;
    end
    chk("t3_dm_grants", dm_grants, 4);
    chk_b("t3_if_granted", if_seen, 1'b1);
    drain();
    auto_mem = 1'b0; mem_ack = 1'b0;

    run_random(2000, 60);

    // Flush during a fetch hides its result; the following fetch is normal.
    if_req = 1'b1; if_addr = 32'h55;
    tick();
    if_flush = 1'b1;
    tick();
    if_flush = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hCAFE_0001;
    tick();
    mem_ack = 1'b0; if_addr = 32'h56;
    #1;
    chk_b("t5_if_valid_dropped", if_valid, 1'b0);
    chk_b("t5_if_stall", if_stall, 1'b1);
    tick();
    tick();
    #1 chk("t5_next_addr", bus.mem_addr, 32'h56);
    mem_ack = 1'b1; mem_rdata = 32'h0000_1234;
    tick();
    mem_ack = 1'b0; if_req = 1'b0;
    #1;
    chk_b("t5_if_valid", if_valid, 1'b1);
    chk("t5_if_rdata", if_rdata, 32'h0000_1234);
    tick();

    // Memory never acknowledges: abort after TMO busy cycles.
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h44;
    auto_mem = 1'b1; ack_pct = 0; hi_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      #1;
      if (bus.mem_req) hi_cnt++;
      else if (hi_cnt > 0) break;
    end
    chk("t4_busy_cycles", hi_cnt, TMO);
    chk_b("t4_err", err, 1'b1);
    chk_b("t4_dm_valid", dm_valid, 1'b1);
    chk("t4_dm_rdata", dm_rdata, 32'h0);
    dm_req = 1'b0;
    tick();
    auto_mem = 1'b0; mem_ack = 1'b0;

    run_random(800, 70);
    #1 chk_b("t4_err_sticky", err, 1'b1);

    // Asynchronous reset in the middle of a data access.
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h99; mem_ack = 1'b0;
    tick();
    #2 rst = 1'b0;
    #1;
    chk_b("t6_mem_req", bus.mem_req, 1'b0);
    chk_b("t6_dm_valid", dm_valid, 1'b0);
    chk_b("t6_err", err, 1'b0);
    dm_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      #1 if (dm_valid || bus.mem_req) pulses++;
    end
    chk("t6_no_pulse", pulses, 0);

    run_random(300, 80);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
